csa_addsub_pipe: RTL and testbench

- Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on both sides.
- Successor to the single-cycle 32-bit carry-select adder used in the ALU:
  - adds subtract mode, carry-in control and a full flag set;
  - register staging allows it to close timing at wider widths.
- Sits between operand select and the ALU result mux in the execute stage.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/csa_segment.sv | 23 ++
 rtl/csa_addsub_pipe.sv | 149 ++++++++++++++
 tb/tb_csa_addsub_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default datapath widths and the
// arithmetic flag bundle used by the execute-stage adder.
package alu_pkg;

    typedef enum logic {
        ALU_OP_ADD = 1'b0,
        ALU_OP_SUB = 1'b1
    } alu_op_e;

    localparam int ALU_WIDTH = 32;
    localparam int CSA_SEG   = 8;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/csa_segment.sv
// One carry-select segment: two ripple sums (cin=0 and cin=1) computed in
// parallel, with the incoming carry picking the result late.
module csa_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] sum_c0;
    logic [SEG:0] sum_c1;

    always_comb begin
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    end

    assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/csa_addsub_pipe.sv
// Two-stage carry-select adder/subtractor with valid/ready on both sides.
// Define CSA_ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module csa_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEG   = CSA_SEG
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int HALF = WIDTH / 2;
    localparam int NSEG = HALF / SEG;

    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic            lo_cout;
        logic [HALF-1:0] a_hi;
        logic [HALF-1:0] b_hi;
        logic            a_msb;
        logic            b_msb;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        alu_flags_t       flags;
    } s2_t;

    logic       s1_valid_d, s1_valid_q;
    logic       s2_valid_d, s2_valid_q;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic       s1_adv, s2_adv, accept;

    // Subtraction is A + ~B + 1; the carry-in pin only matters for add.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [NSEG:0]    lo_c;
    logic [HALF-1:0]  lo_sum;

    assign is_sub  = (op_sub == ALU_OP_SUB);
    assign b_eff   = is_sub ? ~in_b : in_b;
    assign lo_c[0] = is_sub ? 1'b1 : in_cin;

    for (genvar g = 0; g < NSEG; g++) begin : g_lo
        csa_segment #(.SEG(SEG)) u_seg (
            .a    (in_a[g*SEG +: SEG]),
            .b    (b_eff[g*SEG +: SEG]),
            .cin  (lo_c[g]),
            .sum  (lo_sum[g*SEG +: SEG]),
            .cout (lo_c[g+1])
        );
    end

    logic [NSEG:0]    hi_c;
    logic [HALF-1:0]  hi_sum;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    alu_flags_t       res_flags;

    assign hi_c[0] = s1_q.lo_cout;

    for (genvar g = 0; g < NSEG; g++) begin : g_hi
        csa_segment #(.SEG(SEG)) u_seg (
            .a    (s1_q.a_hi[g*SEG +: SEG]),
            .b    (s1_q.b_hi[g*SEG +: SEG]),
            .cin  (hi_c[g]),
            .sum  (hi_sum[g*SEG +: SEG]),
            .cout (hi_c[g+1])
        );
    end

    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        raw_sum        = {hi_sum, s1_q.lo_sum};
        res_sum        = raw_sum;
        res_flags.cout = hi_c[NSEG];
        res_flags.ovf  = (s1_q.a_msb == s1_q.b_msb) && (raw_sum[WIDTH-1] != s1_q.a_msb);
`ifdef CSA_ADDSUB_SATURATE_EN
        if (res_flags.ovf) begin
            res_sum = s1_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        res_flags.zero = (res_sum == '0);
        res_flags.neg  = res_sum[WIDTH-1];
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        accept     = in_valid && s1_adv;

        s1_valid_d = s1_adv ? accept : s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_d = '{lo_sum:  lo_sum,
                     lo_cout: lo_c[NSEG],
                     a_hi:    in_a[WIDTH-1:HALF],
                     b_hi:    b_eff[WIDTH-1:HALF],
                     a_msb:   in_a[WIDTH-1],
                     b_msb:   b_eff[WIDTH-1]};
        end

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv && s1_valid_q) begin
            s2_d = '{sum: res_sum, flags: res_flags};
        end
    end

    // NOTE: data registers are reset too, so out_sum and the flags read zero while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            // NOTE: non-blocking updates so both stages see pre-edge values of each other.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_sum   = s2_q.sum;
    assign out_cout  = s2_q.flags.cout;
    assign out_ovf   = s2_q.flags.ovf;
    assign out_zero  = s2_q.flags.zero;
    assign out_neg   = s2_q.flags.neg;

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Directed bench for csa_addsub_pipe: single ops, a streamed batch, backpressure
// and mid-flight reset; honours CSA_ADDSUB_SATURATE_EN in its expectations.
module tb_csa_addsub_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_cin, op_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_cout, out_ovf, out_zero, out_neg;

    int errors = 0;
    int checks = 0;

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [35:0] exp_q [$];

    csa_addsub_pipe dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed as {cout, ovf, zero, neg, sum}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] r;
        logic [31:0] s;
        logic        ovf;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        s   = r[31:0];
        ovf = (a[31] == bb[31]) && (s[31] != a[31]);
`ifdef CSA_ADDSUB_SATURATE_EN
        if (ovf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r[32], ovf, (s == 32'd0), s[31], s};
    endfunction

    function automatic logic [35:0] observed();
        return {out_cout, out_ovf, out_zero, out_neg, out_sum};
    endfunction

    // Single op on an idle pipe; checks the 2-cycle latency and the result.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [35:0] exp);
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; op_sub = sub; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clock); #1;
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check(tag, 64'(observed()), 64'(exp));
    endtask

    // Streams n ops from va/vb/vc/vs; out_ready is held low for the first `stall` cycles.
    task automatic run_stream(input string tag, input int n, input int stall);
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        held_v = 1'b0;
        logic [35:0] held;
        exp_q.delete();
        while (got < n && cyc < 40) begin
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            if (sent < n) begin
                in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent]; op_sub = vs[sent];
            end
            #1;
            if (stall == 0 && sent < n) check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
            if (stall > 0 && cyc == 2) check({tag, "_in_ready_low"}, 64'(in_ready), 64'(0));
            if (out_valid && got == 0 && !held_v) check({tag, "_first_lat"}, 64'(cyc), 64'(2));
            if (out_valid && !out_ready) begin
                if (held_v) check({tag, "_hold"}, 64'(observed()), 64'(held));
                held   = observed();
                held_v = 1'b1;
            end else if (out_valid) begin
                check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check({tag, "_result"}, 64'(observed()), 64'(exp_q.pop_front()));
                got++;
                held_v = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(va[sent], vb[sent], vc[sent], vs[sent]));
                sent++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        #1;
        check({tag, "_idle"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_data", 64'(observed()), 64'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        check("post_reset_valid", 64'(out_valid), 64'(0));

        // Directed ops with hand-computed {cout, ovf, zero, neg, sum}.
`ifdef CSA_ADDSUB_SATURATE_EN
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {4'b0100, 32'h7FFF_FFFF});
        do_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, {4'b1101, 32'h8000_0000});
`else
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {4'b0101, 32'h8000_0000});
        do_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, {4'b1100, 32'h7FFF_FFFF});
`endif
        do_op("sub_5_7",   32'd5,         32'd7, 1'b0, 1'b1, {4'b0001, 32'hFFFF_FFFE});
        do_op("sub_7_7",   32'd7,         32'd7, 1'b0, 1'b1, {4'b1010, 32'h0000_0000});
        do_op("half_carry", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, {4'b0000, 32'h0001_0000});
        do_op("cin_only",  32'h0,         32'h0, 1'b1, 1'b0, {4'b0000, 32'h0000_0001});
        do_op("wrap",      32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {4'b1010, 32'h0000_0000});
        do_op("sub_cin_ignored", 32'd10,  32'd3, 1'b1, 1'b1, {4'b1000, 32'h0000_0007});
        @(posedge clock); #1;

        // Back-to-back stream of 8 mixed ops.
        va = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0000_0000};
        vb = '{32'h8765_4321, 32'h0BAD_F00D, 32'h0000_0001, 32'h8000_0000,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F1, 32'h0000_0001};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_stream("stream", 8, 0);

        // Three ops against a consumer stalled for 4 cycles.
        va[0] = 32'd100; vb[0] = 32'd1;  vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 32'd200; vb[1] = 32'd50; vc[1] = 1'b0; vs[1] = 1'b1;
        va[2] = 32'd3;   vb[2] = 32'd4;  vc[2] = 1'b1; vs[2] = 1'b0;
        run_stream("backpressure", 3, 4);

        // Reset with two ops in flight.
        in_a = 32'd1; in_b = 32'd2; in_cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_a = 32'd3; in_b = 32'd4;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("flight_valid", 64'(out_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid_reset_valid", 64'(out_valid), 64'(0));
        check("mid_reset_data", 64'(observed()), 64'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("no_stale", 64'(out_valid), 64'(0));
        end
        check("post_mid_reset_ready", 64'(in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
